// File: rtl/tlp_fifo_arbiter.sv
// Merges two framed 72-bit snoop streams onto one FIFO write port.
// Whole frames are granted round-robin; stalled frames are aborted and every frame is followed by a fixed gap.
module tlp_fifo_arbiter #(
  parameter logic [2:0] GAP     = 3'd7,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic [71:0] s0_din,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [71:0] s1_din,
  input  logic        s1_valid,
  output logic        s1_ready,
  output logic [71:0] din,
  output logic        wr_en,
  input  logic        full,
  output logic        grant,
  output logic        busy,
  output logic [15:0] abort_cnt
);

  localparam logic [71:0] ABORT_WORD = 72'h02_0000_0000_0000_0000;

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_ABORT, ST_GAP} state_t;

  localparam state_t POST_FRAME = (GAP != 3'd0) ? ST_GAP : ST_IDLE;

  state_t      state_q;
  logic        grant_q;
  logic        rr_q;
  logic [7:0]  timer_q;
  logic [2:0]  gap_cnt_q;
  logic [71:0] din_q;
  logic        wr_en_q;
  logic [15:0] abort_cnt_q;

  logic        cand0, cand1, go, sel;
  logic        g_valid, x_rdy;
  logic [71:0] g_din, sel_din;

  always_comb begin
    cand0   = s0_valid && s0_din[64];
    cand1   = s1_valid && s1_din[64];
    go      = !full && (cand0 || cand1);
    sel     = (cand0 && cand1) ? rr_q : cand1;
    sel_din = sel ? s1_din : s0_din;
    g_valid = grant_q ? s1_valid : s0_valid;
    g_din   = grant_q ? s1_din : s0_din;
    x_rdy   = !full && !g_din[64];
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    // Readies are held low while reset is asserted so nothing is consumed then.
    if (sys_rst_n) begin
      case (state_q)
        ST_IDLE: begin
          s0_ready = (s0_valid && !s0_din[64]) || (go && !sel);
          s1_ready = (s1_valid && !s1_din[64]) || (go && sel);
        end
        ST_XFER: begin
          s0_ready = x_rdy && !grant_q;
          s1_ready = x_rdy && grant_q;
        end
        default: begin
          s0_ready = 1'b0;
          s1_ready = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b0;
      rr_q        <= 1'b0;
      timer_q     <= '0;
      gap_cnt_q   <= '0;
      din_q       <= '0;
      wr_en_q     <= 1'b0;
      abort_cnt_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            grant_q <= sel;
            din_q   <= sel_din;
            wr_en_q <= 1'b1;
            timer_q <= '0;
            // A start word that is also the last word is a complete one-word frame.
            if (sel_din[65]) begin
              rr_q      <= ~sel;
              gap_cnt_q <= GAP;
              state_q   <= POST_FRAME;
            end else begin
              state_q <= ST_XFER;
            end
          end
        end
        ST_XFER: begin
          if (g_valid && g_din[64]) begin
            state_q <= ST_ABORT;
          end else if (!full) begin
            if (g_valid) begin
              din_q   <= g_din;
              wr_en_q <= 1'b1;
              timer_q <= '0;
              if (g_din[65]) begin
                rr_q      <= ~grant_q;
                gap_cnt_q <= GAP;
                state_q   <= POST_FRAME;
              end
            end else if (timer_q == TIMEOUT - 8'd1) begin
              state_q <= ST_ABORT;
            end else begin
              timer_q <= timer_q + 8'd1;
            end
          end
        end
        ST_ABORT: begin
          if (!full) begin
            din_q     <= ABORT_WORD;
            wr_en_q   <= 1'b1;
            rr_q      <= ~grant_q;
            gap_cnt_q <= GAP;
            state_q   <= POST_FRAME;
            if (abort_cnt_q != 16'hFFFF) abort_cnt_q <= abort_cnt_q + 16'd1;
          end
        end
        ST_GAP: begin
          if (!full) begin
            din_q     <= '0;
            wr_en_q   <= 1'b1;
            gap_cnt_q <= gap_cnt_q - 3'd1;
            if (gap_cnt_q == 3'd1) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign din       = din_q;
  assign wr_en     = wr_en_q;
  assign grant     = grant_q;
  assign busy      = (state_q == ST_XFER) || (state_q == ST_GAP);
  assign abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_tlp_fifo_arbiter.sv
// Directed bench for tlp_fifo_arbiter: expected FIFO writes are queued as stimulus is
// planned and popped by a write monitor; cycle-level behaviour is checked inline.
module tb_tlp_fifo_arbiter;

  localparam logic [71:0] ABORT_WORD = 72'h02_0000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [71:0] s0_din = '0, s1_din = '0;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic        s0_ready, s1_ready;
  logic [71:0] din;
  logic        wr_en;
  logic        full = 1'b0;
  logic        grant, busy;
  logic [15:0] abort_cnt;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [71:0] sb[$];
  int wr_cyc[$];

  tlp_fifo_arbiter #(.GAP(3'd7), .TIMEOUT(8'd8)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .s0_din(s0_din), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_din(s1_din), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .din(din), .wr_en(wr_en), .full(full),
    .grant(grant), .busy(busy), .abort_cnt(abort_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] mk(input logic start, input logic last, input logic [63:0] d);
    return {4'h0, 1'b1, 1'b1, last, start, d};
  endfunction

  function automatic logic [71:0] filler(input logic [63:0] d);
    return {4'h0, 1'b1, 1'b1, 1'b0, 1'b0, d};
  endfunction

  // Write monitor: every FIFO write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && wr_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      if (sb.size() == 0) chk("unexpected_write", din, 72'h0);
      else chk("sb_word", din, sb.pop_front());
    end
  end

  task automatic drive(input int src, input logic [71:0] w, input logic v);
    if (src == 0) begin s0_din = w; s0_valid = v; end
    else begin s1_din = w; s1_valid = v; end
  endtask

  task automatic send(input int src, input logic [71:0] words[$]);
    foreach (words[i]) begin
      logic hs;
      int n;
      hs = 1'b0;
      n = 0;
      drive(src, words[i], 1'b1);
      while (!hs && n < 200) begin
        @(negedge clk);
        hs = (src == 0) ? s0_ready : s1_ready;
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("handshake_s%0d_w%0d", src, i), {71'h0, hs}, 72'h1);
    end
    drive(src, '0, 1'b0);
  endtask

  task automatic push_gap();
    repeat (7) sb.push_back(72'h0);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] fa[$], fb[$], fc[$], f1[$], f3[$], f4[$], f5[$], fl[$], f6[$];
    int cyc0;

    // Reset values
    step(3);
    sys_rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_wr_en", {71'h0, wr_en}, 72'h0);
    chk("rst_din", din, 72'h0);
    chk("rst_busy", {71'h0, busy}, 72'h0);
    chk("rst_grant", {71'h0, grant}, 72'h0);
    chk("rst_abort_cnt", {56'h0, abort_cnt}, 72'h0);
    chk("rst_readies", {70'h0, s1_ready, s0_ready}, 72'h0);
    @(posedge clk); #1;

    // Simultaneous starts: s0 wins (rr=0), then pending s1 beats s0's next frame
    fa = '{mk(1, 0, 64'hA0), mk(0, 1, 64'hA1)};
    fb = '{mk(1, 0, 64'hB0), mk(0, 0, 64'hB1), mk(0, 1, 64'hB2)};
    fc = '{mk(1, 0, 64'hC0), mk(0, 1, 64'hC1)};
    foreach (fa[i]) sb.push_back(fa[i]);
    push_gap();
    foreach (fb[i]) sb.push_back(fb[i]);
    push_gap();
    foreach (fc[i]) sb.push_back(fc[i]);
    push_gap();
    fork
      begin send(0, fa); send(0, fc); end
      send(1, fb);
    join
    step(10);
    chk("rr_sb_drained", 72'(sb.size()), 72'h0);

    // Single 4-word frame on s0 followed by 7 gap words, s1_ready low throughout
    f1 = '{mk(1, 0, 64'h1111_0000), mk(0, 0, 64'h1111_0001),
           mk(0, 0, 64'h1111_0002), mk(0, 1, 64'h1111_0003)};
    foreach (f1[i]) sb.push_back(f1[i]);
    push_gap();
    wr_cyc.delete();
    cyc0 = cyc;
    fork
      send(0, f1);
      begin
        logic s1r_seen;
        s1r_seen = 1'b0;
        repeat (12) begin
          @(negedge clk);
          s1r_seen = s1r_seen | s1_ready;
          @(posedge clk); #1;
        end
        chk("t1_s1_ready_low", {71'h0, s1r_seen}, 72'h0);
      end
    join
    step(2);
    chk("t1_write_count", 72'(wr_cyc.size()), 72'd11);
    if (wr_cyc.size() == 11) begin
      chk("t1_first_latency", 72'(wr_cyc[0] - cyc0), 72'd1);
      chk("t1_contiguous", 72'(wr_cyc[10] - wr_cyc[0]), 72'd10);
    end

    // full for 5 cycles mid-frame: no ready, no write (one-cycle lag), frame intact
    f3 = '{mk(1, 0, 64'h30), mk(0, 0, 64'h31), mk(0, 0, 64'h32),
           mk(0, 0, 64'h33), mk(0, 0, 64'h34), mk(0, 1, 64'h35)};
    foreach (f3[i]) sb.push_back(f3[i]);
    push_gap();
    fork
      send(0, f3);
      begin
        repeat (3) @(posedge clk);
        #1 full = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk($sformatf("t3_ready_full_%0d", k), {71'h0, s0_ready}, 72'h0);
          if (k >= 1) chk($sformatf("t3_no_wr_%0d", k), {71'h0, wr_en}, 72'h0);
          @(posedge clk); #1;
        end
        full = 1'b0;
        @(negedge clk);
        chk("t3_wr_lag", {71'h0, wr_en}, 72'h0);
        chk("t3_ready_resume", {71'h0, s0_ready}, 72'h1);
      end
    join
    step(10);
    chk("t3_sb_drained", 72'(sb.size()), 72'h0);

    // Fillers on s0 during an s1 frame: refused while busy, dropped once IDLE
    f5 = '{mk(1, 0, 64'h50), mk(0, 0, 64'h51), mk(0, 1, 64'h52)};
    foreach (f5[i]) sb.push_back(f5[i]);
    push_gap();
    fork
      send(1, f5);
      begin
        logic s0r_seen;
        s0r_seen = 1'b0;
        @(posedge clk); #1;
        drive(0, filler(64'hF0), 1'b1);
        repeat (9) begin
          @(negedge clk);
          s0r_seen = s0r_seen | s0_ready;
          @(posedge clk); #1;
        end
        chk("t5_s0_ready_busy", {71'h0, s0r_seen}, 72'h0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk($sformatf("t5_filler_accept_%0d", k), {71'h0, s0_ready}, 72'h1);
          @(posedge clk); #1;
          drive(0, filler(64'hF1 + 64'(k)), 1'b1);
        end
        drive(0, '0, 1'b0);
      end
    join
    step(4);
    chk("t5_sb_drained", 72'(sb.size()), 72'h0);

    // s1 stalls after 2 words: abort after 8 idle cycles, then gap; later fillers dropped
    f4 = '{mk(1, 0, 64'h40), mk(0, 0, 64'h41)};
    foreach (f4[i]) sb.push_back(f4[i]);
    sb.push_back(ABORT_WORD);
    push_gap();
    wr_cyc.delete();
    send(1, f4);
    step(20);
    chk("t4_write_count", 72'(wr_cyc.size()), 72'd10);
    if (wr_cyc.size() == 10) chk("t4_abort_delay", 72'(wr_cyc[2] - wr_cyc[1]), 72'd9);
    chk("t4_abort_cnt", {56'h0, abort_cnt}, 72'h1);
    fl = '{filler(64'h42), filler(64'h43), mk(0, 1, 64'h44)};
    send(1, fl);
    step(3);
    chk("t4_sb_drained", 72'(sb.size()), 72'h0);

    // Reset mid-frame: truncated, no abort word, then a normal frame
    sb.push_back(mk(1, 0, 64'h60));
    sb.push_back(mk(0, 0, 64'h61));
    drive(0, mk(1, 0, 64'h60), 1'b1);
    step(1);
    drive(0, mk(0, 0, 64'h61), 1'b1);
    step(1);
    sys_rst_n = 1'b0;
    drive(0, '0, 1'b0);
    step(1);
    sys_rst_n = 1'b1;
    @(negedge clk);
    chk("t6_wr_en", {71'h0, wr_en}, 72'h0);
    chk("t6_din", din, 72'h0);
    chk("t6_busy", {71'h0, busy}, 72'h0);
    chk("t6_abort_cnt", {56'h0, abort_cnt}, 72'h0);
    @(posedge clk); #1;
    f6 = '{mk(1, 0, 64'h70), mk(0, 1, 64'h71)};
    foreach (f6[i]) sb.push_back(f6[i]);
    push_gap();
    send(1, f6);
    step(12);
    chk("t6_grant", {71'h0, grant}, 72'h1);
    chk("t6_abort_cnt_after", {56'h0, abort_cnt}, 72'h0);
    chk("final_sb_drained", 72'(sb.size()), 72'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
